// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: state encoding,
// default operand width and the bit-counter width helper.
package serial_adder_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // The counter must hold 0..WIDTH-1 and is never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/bit_adder_cell.sv
// Combinational one-bit full adder cell.
module bit_adder_cell (
    output logic sum,
    output logic carryout,
    input  logic a,
    input  logic b,
    input  logic carryin
);

    always_comb begin
        sum      = a ^ b ^ carryin;
        carryout = (a & b) | (a & carryin) | (b & carryin);
    end

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: operands are fed LSB-first through a single
// full-adder cell, with the carry recirculated through a flop.
//
// state   | meaning
// --------+--------------------------------------------------------
// IDLE    | waiting for operands, start_ready high
// RUN     | one operand bit pair added per clock, WIDTH clocks
// DONE    | result held on sum_out/cout_out until result_ready
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin_in,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout_out,
    output logic             busy
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sr_q, a_sr_d;
    logic [WIDTH-1:0]   b_sr_q, b_sr_d;
    logic [WIDTH-1:0]   sum_sr_q, sum_sr_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               fa_sum;
    logic               fa_cout;
    logic [WIDTH:0]     sum_ext;

    bit_adder_cell u_fa (
        .sum      (fa_sum),
        .carryout (fa_cout),
        .a        (a_sr_q[0]),
        .b        (b_sr_q[0]),
        .carryin  (carry_q)
    );

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        sum_sr_d = sum_sr_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        // Width-safe form of {s, sum_sr[WIDTH-1:1]}, valid for WIDTH=1 too.
        sum_ext  = {fa_sum, sum_sr_q};

        case (state_q)
            ST_IDLE: begin
                if (start_valid) begin
                    a_sr_d   = a_in;
                    b_sr_d   = b_in;
                    carry_d  = cin_in;
                    cnt_d    = '0;
                    sum_sr_d = '0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                sum_sr_d = sum_ext[WIDTH:1];
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                carry_d  = fa_cout;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (result_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            sum_sr_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            sum_sr_q <= sum_sr_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        start_ready  = (state_q == ST_IDLE);
        result_valid = (state_q == ST_DONE);
        busy         = (state_q != ST_IDLE);
        sum_out      = sum_sr_q;
        cout_out     = carry_q;
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: WIDTH=8 directed/random plus
// exhaustive WIDTH=4 and WIDTH=1 instances.
module tb_serial_adder_ctrl;

    logic clk;
    logic reset;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // WIDTH=8 instance
    logic       sv8, sr8, rv8, rr8, cin8, cout8, busy8;
    logic [7:0] a8, b8, sum8;

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start_valid(sv8), .start_ready(sr8),
        .a_in(a8), .b_in(b8), .cin_in(cin8), .result_valid(rv8),
        .result_ready(rr8), .sum_out(sum8), .cout_out(cout8), .busy(busy8)
    );

    // WIDTH=4 instance
    logic       sv4, sr4, rv4, rr4, cin4, cout4, busy4;
    logic [3:0] a4, b4, sum4;

    serial_adder_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .start_valid(sv4), .start_ready(sr4),
        .a_in(a4), .b_in(b4), .cin_in(cin4), .result_valid(rv4),
        .result_ready(rr4), .sum_out(sum4), .cout_out(cout4), .busy(busy4)
    );

    // WIDTH=1 instance
    logic       sv1, sr1, rv1, rr1, cin1, cout1, busy1;
    logic [0:0] a1, b1, sum1;

    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .reset(reset), .start_valid(sv1), .start_ready(sr1),
        .a_in(a1), .b_in(b1), .cin_in(cin1), .result_valid(rv1),
        .result_ready(rr1), .sum_out(sum1), .cout_out(cout1), .busy(busy1)
    );

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] s;
        logic       co;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: plain integer addition, overflow appears as bit WIDTH.
    function automatic logic [8:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic c);
        int unsigned t;
        t = int'(a) + int'(b) + int'(c);
        return t[8:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic c);
        int i;
        i = 0;
        while (!sr8 && i < 50) begin
            tick();
            i++;
        end
        if (!sr8) chk("start8_timeout", 0, 1);
        a8 = a; b8 = b; cin8 = c; sv8 = 1'b1;
        tick();
        sv8 = 1'b0;
        a8 = $urandom; b8 = $urandom; cin8 = 1'($urandom);
    endtask

    task automatic wait_done8(input string nm);
        int n;
        n = 0;
        do begin
            if (busy8 !== 1'b1 || sr8 !== 1'b0) chk({nm, "_busy_run"}, {busy8, sr8}, 2'b10);
            tick();
            n++;
        end while (!rv8 && n < 50);
        chk({nm, "_latency"}, n, 8);
        chk({nm, "_busy_done"}, {busy8, sr8}, 2'b10);
    endtask

    task automatic consume8(input string nm);
        rr8 = 1'b1;
        tick();
        rr8 = 1'b0;
        chk({nm, "_valid_drop"}, rv8, 0);
        chk({nm, "_idle_ready"}, sr8, 1);
    endtask

    task automatic op8(input string nm, input logic [7:0] a, input logic [7:0] b,
                       input logic c, input logic [7:0] es, input logic eco);
        start8(a, b, c);
        wait_done8(nm);
        chk({nm, "_sum"}, sum8, es);
        chk({nm, "_cout"}, cout8, eco);
        consume8(nm);
        chk({nm, "_hold_sum"}, sum8, es);
    endtask

    initial begin
        logic [8:0] r;
        logic [7:0] ra, rb;
        logic       rc;
        logic [8:0] exp_q[$];
        logic       sr_before, sv_before;
        int         issued, got, last_cyc, n;
        logic [7:0] bb_a[4];
        logic [7:0] bb_b[4];
        logic       bb_c[4];

        tbl[0] = '{8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0};
        tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        tbl[2] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
        tbl[3] = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0};
        tbl[4] = '{8'h01, 8'h02, 1'b1, 8'h04, 1'b0};
        tbl[5] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        tbl[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        tbl[7] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};

        sv8 = 0; rr8 = 0; a8 = 0; b8 = 0; cin8 = 0;
        sv4 = 0; rr4 = 0; a4 = 0; b4 = 0; cin4 = 0;
        sv1 = 0; rr1 = 0; a1 = 0; b1 = 0; cin1 = 0;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;

        chk("reset_outputs", {sr8, rv8, busy8, cout8, sum8}, {1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
        tick();
        chk("idle_no_start", {sr8, busy8}, 2'b10);

        foreach (tbl[i])
            op8($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].s, tbl[i].co);

        for (int i = 0; i < 40; i++) begin
            ra = $urandom; rb = $urandom; rc = 1'($urandom);
            r  = ref8(ra, rb, rc);
            op8($sformatf("rnd%0d", i), ra, rb, rc, r[7:0], r[8]);
        end

        // Backpressure: DONE holds while start pulses are ignored.
        start8(8'h10, 8'h20, 1'b0);
        wait_done8("bp");
        for (int i = 0; i < 5; i++) begin
            sv8 = i[0]; a8 = 8'h77; b8 = 8'h11;
            tick();
            chk("bp_hold", {rv8, sr8, sum8, cout8}, {1'b1, 1'b0, 8'h30, 1'b0});
        end
        // No accept on the edge that completes the result handshake.
        sv8 = 1'b1; rr8 = 1'b1;
        tick();
        rr8 = 1'b0;
        chk("bp_release_idle", {rv8, sr8, busy8, sum8}, {1'b0, 1'b1, 1'b0, 8'h30});
        a8 = 8'h05; b8 = 8'h06; cin8 = 1'b0;
        tick();
        sv8 = 1'b0;
        chk("bp_next_accept", {sr8, busy8}, 2'b01);
        wait_done8("bp2");
        chk("bp2_sum", {cout8, sum8}, 9'h00B);
        consume8("bp2");

        // Reset after three RUN edges discards the operation.
        start8(8'h55, 8'h55, 1'b0);
        tick(); tick(); tick();
        chk("midrun_busy", busy8, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrun_reset", {sr8, rv8, busy8, cout8, sum8}, {1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
        op8("post_reset", 8'h01, 8'h02, 1'b1, 8'h04, 1'b0);

        // Reset while DONE with result_valid high, and priority over result_ready.
        start8(8'hF0, 8'hF0, 1'b1);
        wait_done8("done_rst");
        reset = 1'b1; rr8 = 1'b1; sv8 = 1'b1;
        tick();
        reset = 1'b0; rr8 = 1'b0; sv8 = 1'b0;
        chk("done_reset", {sr8, rv8, busy8, cout8, sum8}, {1'b1, 1'b0, 1'b0, 1'b0, 8'h00});

        // Back-to-back with both handshakes tied high.
        for (int k = 0; k < 4; k++) begin
            bb_a[k] = $urandom; bb_b[k] = $urandom; bb_c[k] = 1'($urandom);
        end
        issued = 0; got = 0; last_cyc = 0;
        a8 = bb_a[0]; b8 = bb_b[0]; cin8 = bb_c[0];
        sv8 = 1'b1; rr8 = 1'b1;
        for (int cyc = 0; cyc < 200 && got < 4; cyc++) begin
            sr_before = sr8;
            sv_before = sv8;
            tick();
            if (sr_before && sv_before) begin
                exp_q.push_back(ref8(bb_a[issued], bb_b[issued], bb_c[issued]));
                issued++;
                if (issued < 4) begin
                    a8 = bb_a[issued]; b8 = bb_b[issued]; cin8 = bb_c[issued];
                end else begin
                    sv8 = 1'b0;
                end
            end
            if (rv8) begin
                if (exp_q.size() == 0) begin
                    chk("b2b_unexpected", 1, 0);
                end else begin
                    r = exp_q.pop_front();
                    chk($sformatf("b2b%0d_result", got), {cout8, sum8}, r);
                end
                chk($sformatf("b2b%0d_ready_low", got), sr8, 0);
                if (got > 0) chk($sformatf("b2b%0d_spacing", got), cyc - last_cyc, 10);
                last_cyc = cyc;
                got++;
            end
        end
        chk("b2b_count", got, 4);
        sv8 = 1'b0; rr8 = 1'b0;

        // Exhaustive WIDTH=4.
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int c = 0; c < 2; c++) begin
                    a4 = 4'(a); b4 = 4'(b); cin4 = 1'(c); sv4 = 1'b1;
                    tick();
                    sv4 = 1'b0;
                    n = 0;
                    while (!rv4 && n < 20) begin
                        tick();
                        n++;
                    end
                    chk($sformatf("w4_%0d_%0d_%0d", a, b, c), {n[7:0], cout4, sum4},
                        {8'd4, 5'(a + b + c)});
                    rr4 = 1'b1;
                    tick();
                    rr4 = 1'b0;
                end

        // Exhaustive WIDTH=1.
        for (int a = 0; a < 2; a++)
            for (int b = 0; b < 2; b++)
                for (int c = 0; c < 2; c++) begin
                    a1 = 1'(a); b1 = 1'(b); cin1 = 1'(c); sv1 = 1'b1;
                    tick();
                    sv1 = 1'b0;
                    n = 0;
                    while (!rv1 && n < 20) begin
                        tick();
                        n++;
                    end
                    chk($sformatf("w1_%0d_%0d_%0d", a, b, c), {n[7:0], cout1, sum1},
                        {8'd1, 2'(a + b + c)});
                    rr1 = 1'b1;
                    tick();
                    rr1 = 1'b0;
                end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial multi-bit adder built around the team's one-bit full-adder cell.
- Accepts two WIDTH-bit operands and a carry-in through a valid/ready handshake.
- Feeds the operands LSB-first through a single full-adder instance, recirculating carryout through a carry flip-flop and shifting sum bits into a result register.
- Presents the WIDTH-bit sum and final carry through an output valid/ready handshake; it is the sequencing stage that feeds and consumes the one-bit adder.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 1..32).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start_valid  input  1  operands present on a_in/b_in/cin_in
- start_ready  output  1  block can accept operands (high only in IDLE)
- a_in  input  WIDTH  operand A
- b_in  input  WIDTH  operand B
- cin_in  input  1  initial carry-in
- result_valid  output  1  sum_out/cout_out hold a finished result
- result_ready  input  1  consumer accepts result
- sum_out  output  WIDTH  A + B + cin, low WIDTH bits
- cout_out  output  1  carry out of bit WIDTH-1
- busy  output  1  high in RUN or DONE

Behaviour:
- Single clock domain. One clock is used; reset is synchronous and active-high: clk, reset.
- Reset values: state=IDLE, start_ready=1, result_valid=0, busy=0, sum_out=0, cout_out=0, internal shift registers, carry and bit counter all 0.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - start_ready=1.
  - On an edge with start_valid=1: load A_sr<=a_in, B_sr<=b_in, carry<=cin_in, cnt<=0, sum_sr<=0, then go to RUN.
  - Otherwise stay in IDLE.
- RUN, on each edge:
  - Full adder takes A_sr[0], B_sr[0] and carry.
  - sum_sr <= {s, sum_sr[WIDTH-1:1]}.
  - A_sr and B_sr shift right by one, zero-filled.
  - carry <= cout.
  - cnt <= cnt+1.
  - When cnt==WIDTH-1 on that edge, go to DONE.
- Latency: exactly WIDTH RUN edges. result_valid rises after the WIDTH-th rising edge following the accepting edge.
- Throughput is one operation per WIDTH+2 cycles minimum (accept, WIDTH run, one DONE cycle).
- DONE:
  - result_valid=1.
  - sum_out=sum_sr and cout_out=carry, both stable and unchanged until the handshake completes.
  - On an edge with result_ready=1: go to IDLE and drop result_valid.
  - result_valid never drops without result_ready.
- start_ready=0 in RUN and DONE. start_valid and operand inputs are ignored outside IDLE; no queuing.
- A new start cannot be accepted on the same edge that completes the result handshake. The first accept is possible on the following edge.
- sum_out/cout_out keep the last result in IDLE until the next accept (they are not cleared). Consumers must use result_valid.
- Width rules:
  - cnt is max($clog2(WIDTH),1) bits wide.
  - The sum is modulo 2^WIDTH and the overflow bit is reported only via cout_out.
  - WIDTH=1 gives exactly one RUN edge.
- Reset asserted in any state, including mid-RUN or DONE with result_valid high: on that edge, return to all reset values. The in-flight operation is discarded and no partial result is presented.
- reset has priority over start_valid and result_ready on the same edge.
- No X propagation: all registers reset. Undriven inputs in IDLE with start_valid=0 have no effect.

Decomposition:
- Shared package holds:
  - the state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - the default WIDTH;
  - a counter-width helper constant.
- One sub-module instance, bit_adder_cell: the combinational one-bit full adder (sum, carryout, a, b, carryin), instantiated once. The FSM, shift registers and carry flop live in serial_adder_ctrl.

Test Plan:
- WIDTH=8, accept 0x3C+0x0F, cin=0 -> sum_out=0x4B, cout_out=0. result_valid rises after the 8th edge following accept; busy high throughout.
- 0xFF+0x01, cin=0 -> sum_out=0x00, cout_out=1. Then 0xA5+0x5A, cin=1 -> sum_out=0x00, cout_out=1.
- Backpressure: result 0x10+0x20 -> 0x30. Hold result_ready=0 for 5 cycles while pulsing start_valid with other operands -> result_valid stays 1, sum_out stays 0x30, start_ready stays 0, no new accept.
- Reset mid-RUN after 3 RUN edges of 0x55+0x55 -> next cycle IDLE, all outputs 0, start_ready=1. Subsequent 0x01+0x02, cin=1 -> 0x04, cout 0.
- Back-to-back: result_ready tied high, start_valid tied high -> results 2+WIDTH cycles apart, each matching its operands, start_ready low during RUN/DONE.
- WIDTH=4 and WIDTH=1 builds: exhaustive a, b, cin (512 and 8 cases) -> {cout_out, sum_out} == a+b+cin for every case.
